// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl shared types: FSM state encodings,
// stall vector constants and Stop/NoStop levels.
package pipe_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // bit k freezes stage k: 0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb
  localparam logic [5:0] STALL_NONE =
    {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
  localparam logic [5:0] STALL_IF =
    {NoStop, NoStop, NoStop, NoStop, Stop, Stop};
  localparam logic [5:0] STALL_ID =
    {NoStop, NoStop, NoStop, Stop, Stop, Stop};
  localparam logic [5:0] STALL_EX =
    {NoStop, NoStop, Stop, Stop, Stop, Stop};
  localparam logic [5:0] STALL_MEM =
    {NoStop, Stop, Stop, Stop, Stop, Stop};
  // front end frozen while id_ex injects bubbles
  localparam logic [5:0] STALL_FRONT =
    {NoStop, NoStop, NoStop, Stop, Stop, Stop};

  localparam int DrainW = 3;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_TRAP_FLUSH = 2'd1,
    S_HALT_DRAIN = 2'd2,
    S_HALTED     = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// Priority encoder: the oldest stage asking
// to stall freezes itself and everything younger.
module pipe_ctrl_stall_encoder
  import pipe_ctrl_pkg::*;
(
  input  logic       req_if_i,
  input  logic       req_id_i,
  input  logic       req_ex_i,
  input  logic       req_mem_i,
  output logic [5:0] stall_o
);

  // oldest requester wins
  always_comb begin
    stall_o = STALL_NONE;
    if (req_mem_i) begin
      stall_o = STALL_MEM;
    end else if (req_ex_i) begin
      stall_o = STALL_EX;
    end else if (req_id_i) begin
      stall_o = STALL_ID;
    end else if (req_if_i) begin
      stall_o = STALL_IF;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect sequencer.
// Debug halt logic enabled by PIPE_CTRL_DEBUG_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int HALT_DRAIN_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        trap_i,
  input  logic        mret_i,
  input  logic [31:0] trap_vec_i,
  input  logic [31:0] mepc_i,
  input  logic        branch_redirect_i,
  input  logic [31:0] branch_target_i,
  input  logic        dbg_halt_req_i,
  input  logic        dbg_resume_req_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        flush_front_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        csr_trap_we_o,
  output logic        dbg_halted_o
);

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [5:0]  enc_stall;
  logic        trap_any;
  logic [31:0] trap_tgt;

  pipe_ctrl_stall_encoder u_stall_encoder (
    .req_if_i  (stallreq_if_i),
    .req_id_i  (stallreq_id_i),
    .req_ex_i  (stallreq_ex_i),
    .req_mem_i (stallreq_mem_i),
    .stall_o   (enc_stall)
  );

  assign trap_any = trap_i | mret_i;
  // trap outranks mret when both are flagged
  assign trap_tgt = trap_i ? trap_vec_i : mepc_i;

`ifdef PIPE_CTRL_DEBUG_EN
  logic [DrainW-1:0] cnt_q, cnt_d;
  logic              halt_go;

  assign halt_go = dbg_halt_req_i &
    ~(stallreq_if_i | stallreq_id_i |
      stallreq_ex_i | stallreq_mem_i);
  assign dbg_halted_o = (state_q == S_HALTED);
`else
  logic unused_dbg;

  assign unused_dbg = ^{dbg_halt_req_i,
    dbg_resume_req_i, 3'(HALT_DRAIN_CYCLES)};
  assign dbg_halted_o = 1'b0;
`endif

  // next state and all pipeline control outputs
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    stall_o       = enc_stall;
    flush_o       = 1'b0;
    flush_front_o = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = target_q;
    csr_trap_we_o = 1'b0;
`ifdef PIPE_CTRL_DEBUG_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      S_RUN: begin
        if (trap_any) begin
          // wait for the data bus before committing
          if (!stallreq_mem_i) begin
            stall_o  = STALL_MEM;
            state_d  = S_TRAP_FLUSH;
            target_d = trap_tgt;
          end
`ifdef PIPE_CTRL_DEBUG_EN
        end else if (halt_go) begin
          state_d = S_HALT_DRAIN;
          cnt_d   = DrainW'(HALT_DRAIN_CYCLES);
`endif
        end else if (branch_redirect_i &&
                     !enc_stall[3]) begin
          redirect_o    = 1'b1;
          flush_front_o = 1'b1;
          redirect_pc_o = branch_target_i;
        end
      end
      S_TRAP_FLUSH: begin
        flush_o       = 1'b1;
        redirect_o    = 1'b1;
        csr_trap_we_o = 1'b1;
        state_d       = S_RUN;
      end
`ifdef PIPE_CTRL_DEBUG_EN
      S_HALT_DRAIN: begin
        stall_o = STALL_FRONT;
        if (trap_any && !stallreq_mem_i) begin
          stall_o  = STALL_MEM;
          state_d  = S_TRAP_FLUSH;
          target_d = trap_tgt;
          cnt_d    = '0;
        end else if (!stallreq_mem_i) begin
          if (cnt_q <= DrainW'(1)) begin
            cnt_d   = '0;
            state_d = S_HALTED;
          end else begin
            cnt_d = cnt_q - DrainW'(1);
          end
        end
      end
      S_HALTED: begin
        stall_o = STALL_FRONT;
        if (dbg_resume_req_i) begin
          state_d = S_RUN;
        end
      end
`endif
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // FSM state and latched redirect target
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q  <= S_RUN;
      target_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

`ifdef PIPE_CTRL_DEBUG_EN
  // halt drain counter
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed
// scenarios plus randomized run vs. reference model.
module tb_pipe_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0040;

  logic        clk_i = 1'b0;
  logic        n_rst_i = 1'b0;
  logic        stallreq_if_i = 1'b0;
  logic        stallreq_id_i = 1'b0;
  logic        stallreq_ex_i = 1'b0;
  logic        stallreq_mem_i = 1'b0;
  logic        trap_i = 1'b0;
  logic        mret_i = 1'b0;
  logic [31:0] trap_vec_i = '0;
  logic [31:0] mepc_i = '0;
  logic        branch_redirect_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        dbg_halt_req_i = 1'b0;
  logic        dbg_resume_req_i = 1'b0;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        flush_front_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        csr_trap_we_o;
  logic        dbg_halted_o;

  int n_chk = 0;
  int n_fail = 0;

  logic [42:0] obs;
  logic [42:0] exp_v;

  pipe_ctrl #(
    .RESET_PC(RPC),
    .HALT_DRAIN_CYCLES(3)
  ) dut (
    .clk_i(clk_i),
    .n_rst_i(n_rst_i),
    .stallreq_if_i(stallreq_if_i),
    .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i),
    .stallreq_mem_i(stallreq_mem_i),
    .trap_i(trap_i),
    .mret_i(mret_i),
    .trap_vec_i(trap_vec_i),
    .mepc_i(mepc_i),
    .branch_redirect_i(branch_redirect_i),
    .branch_target_i(branch_target_i),
    .dbg_halt_req_i(dbg_halt_req_i),
    .dbg_resume_req_i(dbg_resume_req_i),
    .stall_o(stall_o),
    .flush_o(flush_o),
    .flush_front_o(flush_front_o),
    .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o),
    .csr_trap_we_o(csr_trap_we_o),
    .dbg_halted_o(dbg_halted_o)
  );

  always #5 clk_i = ~clk_i;

  // stall flags, flush, flush_front, redirect, csr we, halted, pc
  assign obs = {stall_o, flush_o, flush_front_o,
    redirect_o, csr_trap_we_o, dbg_halted_o,
    redirect_pc_o};

  function automatic logic [42:0] pk(
    input logic [5:0] st, input logic fl,
    input logic ff, input logic rd, input logic we,
    input logic h, input logic [31:0] pc);
    return {st, fl, ff, rd, we, h, pc};
  endfunction

  // stage k asking to wait freezes stages 0..k
  function automatic logic [5:0] ref_stall(
    input logic [4:1] rq);
    int oldest;
    oldest = 0;
    for (int k = 1; k <= 4; k++) begin
      if (rq[k]) oldest = k;
    end
    return 6'((1 << (oldest + 1)) - 1) &
      ((oldest == 0) ? 6'd0 : 6'h3f);
  endfunction

  task automatic idle();
    stallreq_if_i = 0; stallreq_id_i = 0;
    stallreq_ex_i = 0; stallreq_mem_i = 0;
    trap_i = 0; mret_i = 0;
    branch_redirect_i = 0;
    dbg_halt_req_i = 0; dbg_resume_req_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle();
    n_rst_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_rst_i = 1;
  endtask

  task automatic test_reset();
    idle();
    n_rst_i = 0;
    #12;
    exp_v = pk(6'b0, 0, 0, 0, 0, 0, RPC);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", obs, exp_v);
    end
    @(negedge clk_i);
    n_rst_i = 1;
  endtask

  task automatic test_ex_stall();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      stallreq_ex_i = (i < 4);
      #2;
      exp_v = pk((i < 4) ? 6'b001111 : 6'b0,
        0, 0, 0, 0, 0, RPC);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL ex_stall c%0d: got %h want %h",
          i, obs, exp_v);
      end
    end
  endtask

  task automatic test_combos();
    logic [4:1] rq;
    logic [5:0] want [4];
    logic [4:1] pat [4];
    pat[0] = 4'b1010; want[0] = 6'b011111;
    pat[1] = 4'b0101; want[1] = 6'b001111;
    pat[2] = 4'b0011; want[2] = 6'b000111;
    pat[3] = 4'b0001; want[3] = 6'b000011;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      rq = pat[i];
      stallreq_if_i = rq[1]; stallreq_id_i = rq[2];
      stallreq_ex_i = rq[3]; stallreq_mem_i = rq[4];
      #2;
      n_chk++;
      if (stall_o !== want[i]) begin
        n_fail++;
        $display("FAIL combo %b: got %b want %b",
          rq, stall_o, want[i]);
      end
    end
    idle();
  endtask

  task automatic test_trap();
    do_reset();
    @(negedge clk_i);
    trap_i = 1; trap_vec_i = 32'h8000_0100;
    #2;
    exp_v = pk(6'b011111, 0, 0, 0, 0, 0, RPC);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL trap_n: got %h want %h", obs, exp_v);
    end
    @(negedge clk_i);
    trap_i = 0;
    #2;
    exp_v = pk(6'b0, 1, 0, 1, 1, 0, 32'h8000_0100);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL trap_n1: got %h want %h", obs, exp_v);
    end
    @(negedge clk_i);
    #2;
    exp_v = pk(6'b0, 0, 0, 0, 0, 0, 32'h8000_0100);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL trap_n2: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_trap_branch();
    do_reset();
    @(negedge clk_i);
    trap_i = 1; trap_vec_i = 32'h0000_2000;
    branch_redirect_i = 1; branch_target_i = 32'h1234;
    #2;
    exp_v = pk(6'b011111, 0, 0, 0, 0, 0, RPC);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL trap_br_n: got %h want %h",
        obs, exp_v);
    end
    @(negedge clk_i);
    trap_i = 0; branch_redirect_i = 0;
    #2;
    exp_v = pk(6'b0, 1, 0, 1, 1, 0, 32'h0000_2000);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL trap_br_n1: got %h want %h",
        obs, exp_v);
    end
  endtask

  task automatic test_mret_mem_stall();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      mret_i = (i < 3);
      mepc_i = 32'h0000_0abc;
      stallreq_mem_i = (i < 2);
      #2;
      if (i < 3) exp_v = pk(6'b011111, 0, 0, 0, 0, 0, RPC);
      else exp_v = pk(6'b0, 1, 0, 1, 1, 0, 32'h0abc);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL mret_mem c%0d: got %h want %h",
          i, obs, exp_v);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk_i);
    trap_i = 1; trap_vec_i = 32'h0000_7700;
    @(negedge clk_i);
    trap_i = 0;
    n_rst_i = 0;
    #1;
    exp_v = pk(6'b0, 0, 0, 0, 0, 0, RPC);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL rst_mid: got %h want %h", obs, exp_v);
    end
    @(negedge clk_i);
    n_rst_i = 1;
    #2;
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL rst_after: got %h want %h",
        obs, exp_v);
    end
  endtask

  task automatic test_random();
    logic        pend;
    logic [31:0] tgt;
    logic [4:1]  rq;
    logic [5:0]  e_st;
    logic        e_fl, e_ff, e_rd, e_we;
    logic [31:0] e_pc;
    do_reset();
    pend = 0;
    tgt = RPC;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      for (int k = 1; k <= 4; k++)
        rq[k] = ($urandom_range(0, 3) == 0);
      stallreq_if_i = rq[1]; stallreq_id_i = rq[2];
      stallreq_ex_i = rq[3]; stallreq_mem_i = rq[4];
      trap_i = ($urandom_range(0, 7) == 0);
      mret_i = ($urandom_range(0, 7) == 0);
      branch_redirect_i = ($urandom_range(0, 2) == 0);
      trap_vec_i = $urandom;
      mepc_i = $urandom;
      branch_target_i = $urandom;
      #2;
      e_st = ref_stall(rq);
      e_fl = 0; e_ff = 0; e_rd = 0; e_we = 0;
      e_pc = tgt;
      if (pend) begin
        e_fl = 1; e_rd = 1; e_we = 1;
      end else if (trap_i || mret_i) begin
        if (!rq[4]) e_st = 6'b011111;
      end else if (branch_redirect_i && !e_st[3]) begin
        e_rd = 1; e_ff = 1; e_pc = branch_target_i;
      end
      exp_v = pk(e_st, e_fl, e_ff, e_rd, e_we, 0, e_pc);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rand c%0d: got %h want %h",
          c, obs, exp_v);
      end
      if (pend) begin
        pend = 0;
      end else if ((trap_i || mret_i) && !rq[4]) begin
        pend = 1;
        tgt = trap_i ? trap_vec_i : mepc_i;
      end
    end
    idle();
  endtask

`ifdef PIPE_CTRL_DEBUG_EN
  task automatic test_debug();
    do_reset();
    @(negedge clk_i);
    dbg_halt_req_i = 1;
    #2;
    exp_v = pk(6'b0, 0, 0, 0, 0, 0, RPC);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL dbg_accept: got %h want %h",
        obs, exp_v);
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_i);
      if (i == 5) dbg_halt_req_i = 0;
      #2;
      exp_v = pk(6'b000111, 0, 0, 0, 0, i >= 4, RPC);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL dbg_drain c%0d: got %h want %h",
          i, obs, exp_v);
      end
    end
    @(negedge clk_i);
    dbg_resume_req_i = 1;
    #2;
    n_chk++;
    if (dbg_halted_o !== 1'b1) begin
      n_fail++;
      $display("FAIL dbg_resume_cyc: got %b want 1",
        dbg_halted_o);
    end
    @(negedge clk_i);
    dbg_resume_req_i = 0;
    #2;
    exp_v = pk(6'b0, 0, 0, 0, 0, 0, RPC);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL dbg_resumed: got %h want %h",
        obs, exp_v);
    end
    do_reset();
    @(negedge clk_i);
    dbg_halt_req_i = 1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_i);
      dbg_halt_req_i = 0;
      stallreq_mem_i = (i <= 2);
      #2;
      n_chk++;
      if (dbg_halted_o !== (i >= 6)) begin
        n_fail++;
        $display("FAIL dbg_memdrain c%0d: got %b want %b",
          i, dbg_halted_o, i >= 6);
      end
    end
    idle();
  endtask
`else
  task automatic test_debug();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      dbg_halt_req_i = 1;
      dbg_resume_req_i = (i == 3);
      #2;
      exp_v = pk(6'b0, 0, 0, 0, 0, 0, RPC);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL dbg_off c%0d: got %h want %h",
          i, obs, exp_v);
      end
    end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_ex_stall();
    test_combos();
    test_trap();
    test_trap_branch();
    test_mret_mem_stall();
    test_reset_mid();
    test_debug();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
